// File: rtl/lt24_touch_scan_ctrl.sv
// Autonomous X/Y scan sequencer for the LT24 touch ADC, driving the SPI master's
// Avalon register port: every register access is a 3-cycle select/hold/release.
module lt24_touch_scan_ctrl #(
    parameter logic [7:0] CMD_X      = 8'hD0,
    parameter logic [7:0] CMD_Y      = 8'h90,
    parameter int         PERIOD     = 50000,
    parameter int         POLL_LIMIT = 8191
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        penirq_n,
    output logic        spi_select,
    output logic [2:0]  spi_mem_addr,
    output logic        spi_read_n,
    output logic        spi_write_n,
    output logic [15:0] spi_wrdata,
    input  logic [15:0] spi_rddata,
    output logic [11:0] touch_x,
    output logic [11:0] touch_y,
    output logic        touch_valid,
    output logic        pen_down,
    output logic        busy,
    output logic        timeout_err
);

    localparam int WAIT_W = $clog2(PERIOD);
    localparam int POLL_W = $clog2(POLL_LIMIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(PERIOD - 1);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_LIMIT - 1);
    localparam logic [POLL_W-1:0] POLL_MAX  = POLL_W'(POLL_LIMIT);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SS_ON   = 3'd1;
    localparam logic [2:0] S_TX      = 3'd2;
    localparam logic [2:0] S_POLL    = 3'd3;
    localparam logic [2:0] S_RX      = 3'd4;
    localparam logic [2:0] S_SS_OFF  = 3'd5;
    localparam logic [2:0] S_PUBLISH = 3'd6;
    localparam logic [2:0] S_WAIT    = 3'd7;

    logic [2:0]        state_q, state_d;
    logic [1:0]        phase_q, phase_d;
    logic [2:0]        byte_idx_q, byte_idx_d;
    logic [POLL_W-1:0] poll_cnt_q, poll_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              abort_q, abort_d;
    logic              rrdy_q, rrdy_d;
    logic [11:0]       x_q, x_d, y_q, y_d;
    logic [11:0]       touch_x_q, touch_x_d, touch_y_q, touch_y_d;
    logic              touch_valid_q, touch_valid_d;
    logic              timeout_q, timeout_d;
    logic [1:0]        pen_sync_q;
    logic              pen_down_q, pen_down_d;
    logic              in_access;
    logic [7:0]        tx_byte;
    logic              rddata_unused;

    assign in_access     = state_q inside {S_SS_ON, S_TX, S_POLL, S_RX, S_SS_OFF};
    assign rddata_unused = ^spi_rddata[15:8];

    always_comb begin
        case (byte_idx_q)
            3'd0:    tx_byte = CMD_X;
            3'd3:    tx_byte = CMD_Y;
            default: tx_byte = 8'h00;
        endcase
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        spi_select   = 1'b0;
        spi_read_n   = 1'b1;
        spi_write_n  = 1'b1;
        spi_mem_addr = 3'd0;
        spi_wrdata   = 16'h0000;
        if (in_access && phase_q != 2'd2) begin
            case (state_q)
                S_SS_ON: begin
                    spi_select = 1'b1; spi_write_n = 1'b0;
                    spi_mem_addr = 3'd3; spi_wrdata = 16'h0400;
                end
                S_TX: begin
                    spi_select = 1'b1; spi_write_n = 1'b0;
                    spi_mem_addr = 3'd1; spi_wrdata = {8'h00, tx_byte};
                end
                S_POLL: begin
                    spi_select = 1'b1; spi_read_n = 1'b0; spi_mem_addr = 3'd2;
                end
                S_RX: begin
                    spi_select = 1'b1; spi_read_n = 1'b0; spi_mem_addr = 3'd0;
                end
                S_SS_OFF: begin
                    spi_select = 1'b1; spi_write_n = 1'b0; spi_mem_addr = 3'd3;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        byte_idx_d    = byte_idx_q;
        poll_cnt_d    = poll_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        abort_d       = abort_q;
        rrdy_d        = rrdy_q;
        x_d           = x_q;
        y_d           = y_q;
        touch_x_d     = touch_x_q;
        touch_y_d     = touch_y_q;
        touch_valid_d = 1'b0;
        timeout_d     = timeout_q;
        // The ADC drives penirq while converting, so the pen state is frozen mid-scan.
        pen_down_d    = (state_q == S_IDLE || state_q == S_WAIT) ? ~pen_sync_q[1] : pen_down_q;

        if (in_access) phase_d = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;

        case (state_q)
            S_IDLE: if (enable && pen_down_q) state_d = S_SS_ON;
            S_SS_ON: if (phase_q == 2'd2) begin
                state_d = S_TX; byte_idx_d = 3'd0; abort_d = 1'b0;
            end
            S_TX: if (phase_q == 2'd2) begin
                state_d = S_POLL; poll_cnt_d = '0;
            end
            S_POLL: begin
                if (phase_q == 2'd1) rrdy_d = spi_rddata[7];
                if (phase_q == 2'd2) begin
                    if (rrdy_q) state_d = S_RX;
                    else if (poll_cnt_q == POLL_LAST) begin
                        poll_cnt_d = POLL_MAX; timeout_d = 1'b1;
                        abort_d = 1'b1; state_d = S_SS_OFF;
                    end else poll_cnt_d = poll_cnt_q + POLL_W'(1);
                end
            end
            S_RX: begin
                if (phase_q == 2'd1) begin
                    case (byte_idx_q)
                        3'd1: x_d[11:5] = spi_rddata[6:0];
                        3'd2: x_d[4:0]  = spi_rddata[7:3];
                        3'd4: y_d[11:5] = spi_rddata[6:0];
                        3'd5: y_d[4:0]  = spi_rddata[7:3];
                        default: ;
                    endcase
                end
                if (phase_q == 2'd2) begin
                    byte_idx_d = byte_idx_q + 3'd1;
                    state_d    = (byte_idx_q == 3'd5) ? S_SS_OFF : S_TX;
                end
            end
            S_SS_OFF: if (phase_q == 2'd2) begin
                state_d = abort_q ? S_WAIT : S_PUBLISH; wait_cnt_d = '0;
            end
            S_PUBLISH: begin
                touch_x_d = x_q; touch_y_d = y_q; touch_valid_d = 1'b1;
                timeout_d = 1'b0; state_d = S_WAIT; wait_cnt_d = '0;
            end
            S_WAIT: begin
                if (!enable || !pen_down_q) state_d = S_IDLE;
                else if (wait_cnt_q == WAIT_LAST) state_d = S_SS_ON;
                else wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            phase_q       <= 2'd0;
            byte_idx_q    <= 3'd0;
            poll_cnt_q    <= '0;
            wait_cnt_q    <= '0;
            abort_q       <= 1'b0;
            rrdy_q        <= 1'b0;
            x_q           <= 12'h000;
            y_q           <= 12'h000;
            touch_x_q     <= 12'h000;
            touch_y_q     <= 12'h000;
            touch_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            pen_sync_q    <= 2'b11;
            pen_down_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            byte_idx_q    <= byte_idx_d;
            poll_cnt_q    <= poll_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            abort_q       <= abort_d;
            rrdy_q        <= rrdy_d;
            x_q           <= x_d;
            y_q           <= y_d;
            touch_x_q     <= touch_x_d;
            touch_y_q     <= touch_y_d;
            touch_valid_q <= touch_valid_d;
            timeout_q     <= timeout_d;
            pen_sync_q    <= {pen_sync_q[0], penirq_n};
            pen_down_q    <= pen_down_d;
        end
    end

    assign touch_x     = touch_x_q;
    assign touch_y     = touch_y_q;
    assign touch_valid = touch_valid_q;
    assign pen_down    = pen_down_q;
    assign busy        = in_access;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_lt24_touch_scan_ctrl.sv
// Bench for lt24_touch_scan_ctrl: a behavioural SPI-core/ADC model answers the
// register accesses with random latency and random filler bits.
module tb_lt24_touch_scan_ctrl;

    localparam int PERIOD     = 1000;
    localparam int POLL_LIMIT = 100;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        penirq_n = 1'b1;
    logic        spi_select, spi_read_n, spi_write_n;
    logic [2:0]  spi_mem_addr;
    logic [15:0] spi_wrdata, spi_rddata;
    logic [11:0] touch_x, touch_y;
    logic        touch_valid, pen_down, busy, timeout_err;

    lt24_touch_scan_ctrl #(.PERIOD(PERIOD), .POLL_LIMIT(POLL_LIMIT)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .penirq_n(penirq_n),
        .spi_select(spi_select), .spi_mem_addr(spi_mem_addr),
        .spi_read_n(spi_read_n), .spi_write_n(spi_write_n),
        .spi_wrdata(spi_wrdata), .spi_rddata(spi_rddata),
        .touch_x(touch_x), .touch_y(touch_y), .touch_valid(touch_valid),
        .pen_down(pen_down), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // SPI core / ADC model state
    logic        rrdy_m = 1'b0;
    logic [7:0]  rx_m = 8'h00;
    bit          sso = 1'b0, no_rrdy = 1'b0, prev_sel = 1'b0;
    int          cyc = 0, acc_cnt = 0, valid_cnt = 0, busy_cnt = 0, proto_err = 0;
    int          polls = 0, tx_cnt = 0, byte_k = 0, pend = -1, sel_len = 0;
    logic [11:0] cur_x = 12'h000, cur_y = 12'h000, scan_x = 12'h000, scan_y = 12'h000;
    logic [20:0] acc_sig;
    logic [18:0] wr_q[$];
    logic [18:0] exp_seq[8];
    int          valid_t[$], sso_on_t[$];
    int          n_checks = 0, n_fail = 0;

    assign spi_rddata = (spi_mem_addr == 3'd2) ? {8'h00, rrdy_m, 7'h00} :
                        (spi_mem_addr == 3'd0) ? {8'h00, rx_m} : 16'h0000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] adc_byte(input int k);
        logic [7:0] r;
        r = 8'($urandom);
        case (k)
            1:       return {r[7], scan_x[11:5]};
            2:       return {scan_x[4:0], r[2:0]};
            4:       return {r[7], scan_y[11:5]};
            5:       return {scan_y[4:0], r[2:0]};
            default: return r;
        endcase
    endfunction

    task automatic on_access();
        acc_cnt++;
        if (!spi_write_n) begin
            wr_q.push_back({spi_mem_addr, spi_wrdata});
            if (spi_mem_addr == 3'd3) begin
                if (spi_wrdata[10]) begin
                    sso = 1'b1; byte_k = 0; tx_cnt = 0; rrdy_m = 1'b0; pend = -1;
                    scan_x = cur_x; scan_y = cur_y; sso_on_t.push_back(cyc);
                end else sso = 1'b0;
            end else if (spi_mem_addr == 3'd1) begin
                if (!sso) proto_err++;
                rx_m = adc_byte(byte_k);
                byte_k++; tx_cnt++; polls = 0;
                if (!no_rrdy) pend = $urandom_range(0, 4);
            end
        end else if (spi_mem_addr == 3'd2) polls++;
        else if (spi_mem_addr == 3'd0) rrdy_m = 1'b0;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            sso = 1'b0; rrdy_m = 1'b0; pend = -1; prev_sel = 1'b0; sel_len = 0;
        end else begin
            if (pend > 0) pend--;
            else if (pend == 0) begin rrdy_m = 1'b1; pend = -1; end
            if (spi_select) begin
                sel_len++;
                if (spi_read_n == spi_write_n) proto_err++;
                if (!prev_sel) begin
                    acc_sig = {spi_read_n, spi_write_n, spi_mem_addr, spi_wrdata};
                    on_access();
                end else if ({spi_read_n, spi_write_n, spi_mem_addr, spi_wrdata} != acc_sig)
                    proto_err++;
            end else if (prev_sel) begin
                if (sel_len != 2) proto_err++;
                sel_len = 0;
            end
            prev_sel = spi_select;
            if (busy) busy_cnt++;
            if (touch_valid) begin
                valid_cnt++;
                valid_t.push_back(cyc);
                check("touch_x", touch_x, scan_x);
                check("touch_y", touch_y, scan_y);
            end
        end
    end

    task automatic wait_valid(input int target, input int budget, input string tag);
        int k = 0;
        while (valid_cnt < target && k < budget) begin @(negedge clk); k++; end
        if (valid_cnt < target) check({tag, "_timeout"}, valid_cnt, target);
    endtask

    task automatic check_seq(input string tag);
        check({tag, "_len"}, wr_q.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < wr_q.size()) check($sformatf("%s_w%0d", tag, i), wr_q[i], exp_seq[i]);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_sel"}, spi_select, 0);
        check({tag, "_rd"}, spi_read_n, 1);
        check({tag, "_wr"}, spi_write_n, 1);
        check({tag, "_addr"}, spi_mem_addr, 0);
        check({tag, "_wdata"}, spi_wrdata, 0);
        check({tag, "_x"}, touch_x, 0);
        check({tag, "_y"}, touch_y, 0);
        check({tag, "_valid"}, touch_valid, 0);
        check({tag, "_pen"}, pen_down, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_tmo"}, timeout_err, 0);
    endtask

    initial begin
        int v0, a0, k, gap;
        logic [11:0] old_x, old_y;
        logic [18:0] last_wr;
        exp_seq[0] = {3'd3, 16'h0400}; exp_seq[1] = {3'd1, 16'h00D0};
        exp_seq[2] = {3'd1, 16'h0000}; exp_seq[3] = {3'd1, 16'h0000};
        exp_seq[4] = {3'd1, 16'h0090}; exp_seq[5] = {3'd1, 16'h0000};
        exp_seq[6] = {3'd1, 16'h0000}; exp_seq[7] = {3'd3, 16'h0000};

        enable = 1'b1; penirq_n = 1'b1; cur_x = 12'hABC; cur_y = 12'h123;
        repeat (3) @(negedge clk);
        check_reset("rst");
        reset_n = 1'b1;

        // Pen up: no bus activity at all
        repeat (2000) @(negedge clk);
        check("penup_acc", acc_cnt, 0);
        check("penup_busy", busy_cnt, 0);
        check("penup_valid", valid_cnt, 0);
        check("penup_pen", pen_down, 0);

        // Directed scan X=ABC, Y=123
        wr_q.delete();
        penirq_n = 1'b0;
        wait_valid(1, 600, "scan1");
        check_seq("scan1");
        check("scan1_pen", pen_down, 1);
        repeat (5) @(negedge clk);
        check("scan1_pulses", valid_cnt, 1);
        check("scan1_vlow", touch_valid, 0);
        check("scan1_xhold", touch_x, 12'hABC);
        check("scan1_yhold", touch_y, 12'h123);

        // Periodic scanning with random coordinates
        penirq_n = 1'b1;
        repeat (400) @(negedge clk);
        valid_t.delete(); sso_on_t.delete(); v0 = valid_cnt;
        penirq_n = 1'b0;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            cur_x = 12'($urandom); cur_y = 12'($urandom);
            @(negedge clk);
        end
        check("periodic_pulses", valid_cnt - v0, 3);
        for (int i = 0; i < 2; i++) begin
            gap = (valid_t.size() > i && sso_on_t.size() > i + 1) ? sso_on_t[i+1] - valid_t[i] : -1;
            check($sformatf("period_gap%0d", i), (gap >= PERIOD - 2 && gap <= PERIOD + 2), 1);
        end

        // RRDY never set: poll timeout
        penirq_n = 1'b1;
        repeat (400) @(negedge clk);
        no_rrdy = 1'b1; old_x = touch_x; old_y = touch_y; v0 = valid_cnt;
        wr_q.delete();
        penirq_n = 1'b0;
        k = 0;
        while (!timeout_err && k < 2000) begin @(negedge clk); k++; end
        k = 0;
        while (busy && k < 50) begin @(negedge clk); k++; end
        repeat (2) @(negedge clk);
        check("tmo_flag", timeout_err, 1);
        check("tmo_polls", polls, POLL_LIMIT);
        check("tmo_nwr", wr_q.size(), 3);
        last_wr = (wr_q.size() > 0) ? wr_q[wr_q.size()-1] : 19'h7FFFF;
        check("tmo_last_wr", last_wr, {3'd3, 16'h0000});
        check("tmo_novalid", valid_cnt, v0);
        check("tmo_xhold", touch_x, old_x);
        check("tmo_yhold", touch_y, old_y);
        no_rrdy = 1'b0; cur_x = 12'($urandom); cur_y = 12'($urandom);
        wait_valid(v0 + 1, PERIOD + 600, "recover");
        check("recover_tmo_clr", timeout_err, 0);

        // enable dropped while byte 2 is in flight
        k = 0; v0 = sso_on_t.size();
        while (!(sso_on_t.size() > v0 && tx_cnt >= 3) && k < PERIOD + 600) begin
            @(negedge clk); k++;
        end
        enable = 1'b0; v0 = valid_cnt;
        k = 0;
        while (busy && k < 400) begin @(negedge clk); k++; end
        repeat (5) @(negedge clk);
        check("endrop_pub", valid_cnt, v0 + 1);
        a0 = acc_cnt;
        repeat (2 * PERIOD) @(negedge clk);
        check("endrop_noacc", acc_cnt, a0);
        check("endrop_nopulse", valid_cnt, v0 + 1);
        check("endrop_pen", pen_down, 1);
        check("endrop_busy", busy, 0);

        // Reset asserted during POLL
        enable = 1'b1;
        k = 0;
        while (!(spi_select && spi_mem_addr == 3'd2) && k < PERIOD + 200) begin
            @(negedge clk); k++;
        end
        check("poll_reached", spi_mem_addr, 3'd2);
        reset_n = 1'b0;
        #1;
        check_reset("midrst");
        repeat (2) @(negedge clk);
        wr_q.delete(); v0 = valid_cnt;
        reset_n = 1'b1;
        wait_valid(v0 + 1, 800, "postrst");
        check_seq("postrst");

        check("bus_protocol", proto_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
